// File: rtl/qcl_pkg.sv
// Shared types and constants for the qcl credit-return path.
package qcl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SEND  = 2'd2
   } qcl_cr_state_e;

   // A programmed threshold below this value behaves as this value.
   localparam int QCL_MIN_THRESH = 1;

endpackage

// File: rtl/qcl_counter_overflow_clear_en.sv
// Saturating up-counter with synchronous clear, count enable and a sticky
// flag that records an increment attempted while already at all-ones.
module qcl_counter_overflow_clear_en #(
   parameter int width_p = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               en,
   output logic [width_p-1:0] count,
   output logic               overflow
);

   localparam logic [width_p-1:0] one_c = {{(width_p-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (en) begin
         if (&count) begin
            overflow <= 1'b1;
         end else begin
            count <= count + one_c;
         end
      end
   end

endmodule

// File: rtl/qcl_credit_return_accum.sv
// Credit-return accumulator: batches locally freed credits and returns them
// over a valid/ready channel. Define QCL_CREDIT_TIMEOUT_EN for the idle flush.
module qcl_credit_return_accum
   import qcl_pkg::*;
#(
   parameter int width_p         = 8,
   parameter int timeout_width_p = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       clear_i,
   input  logic                       en_i,
   input  logic [width_p-1:0]         thresh_i,
   input  logic [timeout_width_p-1:0] timeout_i,
   output logic                       ret_v_o,
   output logic [width_p-1:0]         ret_count_o,
   input  logic                       ret_ready_i,
   output logic [width_p-1:0]         count_o,
   output logic                       overflow_o,
   output qcl_cr_state_e              state_o
);

   // Return channel: a batch is offered with ret_v_o=1 and ret_count_o held
   // constant; it transfers on a rising clk_i edge where ret_v_o and
   // ret_ready_i are both 1. ret_ready_i may lead or stay high permanently.

   localparam logic [width_p-1:0] min_thresh_c = width_p'(QCL_MIN_THRESH);
   localparam logic [width_p-1:0] one_c        = {{(width_p-1){1'b0}}, 1'b1};

   qcl_cr_state_e      state_r, state_n;
   logic [width_p-1:0] count_r, count_n;
   logic [width_p-1:0] ret_count_r, ret_count_n;
   logic               ovf_r, ovf_n;
   logic [width_p-1:0] inc;
   logic [width_p-1:0] thresh_eff;
   logic               sat_drop;
   logic               timeout_hit;
   logic               flush;

   assign thresh_eff = (thresh_i < min_thresh_c) ? min_thresh_c : thresh_i;
   assign sat_drop   = en_i & (&count_r);
   assign inc        = sat_drop ? count_r : (count_r + {{(width_p-1){1'b0}}, en_i});

`ifdef QCL_CREDIT_TIMEOUT_EN
   localparam logic [timeout_width_p-1:0] t_one_c = {{(timeout_width_p-1){1'b0}}, 1'b1};

   logic [timeout_width_p-1:0] idle_r;
   logic                       idle_clear;
   logic                       idle_unused_sat;

   // The idle count only runs through silent ACCUM cycles; everything else zeroes it.
   assign idle_clear = clear_i | (state_r != ACCUM) | en_i | flush;

   qcl_counter_overflow_clear_en #(
      .width_p (timeout_width_p)
   ) u_idle (
      .clk      (clk_i),
      .rst      (reset_i),
      .clear    (idle_clear),
      .en       (1'b1),
      .count    (idle_r),
      .overflow (idle_unused_sat)
   );

   assign timeout_hit = (timeout_i != '0) & ~en_i & (idle_r == (timeout_i - t_one_c));
`else
   logic unused_timeout;
   assign unused_timeout = ^timeout_i;
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_n     = state_r;
      count_n     = count_r;
      ret_count_n = ret_count_r;
      ovf_n       = ovf_r | sat_drop;
      flush       = 1'b0;
      if (clear_i) begin
         state_n     = IDLE;
         count_n     = '0;
         ret_count_n = '0;
         ovf_n       = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (en_i) begin
                  if (thresh_eff == min_thresh_c) begin
                     state_n     = SEND;
                     ret_count_n = one_c;
                  end else begin
                     state_n = ACCUM;
                     count_n = one_c;
                  end
               end
            end
            ACCUM: begin
               flush = (inc >= thresh_eff) | timeout_hit;
               if (flush) begin
                  state_n     = SEND;
                  ret_count_n = inc;
                  count_n     = '0;
               end else begin
                  count_n = inc;
               end
            end
            SEND: begin
               count_n = inc;
               // Threshold is looked at again only once back in ACCUM.
               if (ret_ready_i) begin
                  ret_count_n = '0;
                  state_n     = (inc != '0) ? ACCUM : IDLE;
               end
            end
            default: begin
               state_n     = IDLE;
               count_n     = '0;
               ret_count_n = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r     <= IDLE;
         count_r     <= '0;
         ret_count_r <= '0;
         ovf_r       <= 1'b0;
      end else begin
         state_r     <= state_n;
         count_r     <= count_n;
         ret_count_r <= ret_count_n;
         ovf_r       <= ovf_n;
      end
   end

   assign ret_v_o     = (state_r == SEND);
   assign ret_count_o = ret_count_r;
   assign count_o     = count_r;
   assign overflow_o  = ovf_r;
   assign state_o     = state_r;

endmodule

// File: doc/qcl_credit_return_accum.md
# qcl_credit_return_accum

Credit-return accumulator: the issuing end of the credit loop whose consuming end is a load/decrement credit counter. It counts credits freed locally, one per cycle, and returns them to the credit holder in batches over a valid/ready channel. A batch is flushed when it reaches a programmable threshold, or when no new credit has arrived for a programmable number of cycles. Credits that arrive while a batch is in flight are accumulated and never lost.

## Interface
Parameters:
- width_p, 8, width of the accumulator and of the returned batch count.
- timeout_width_p, 8, width of the idle-timeout count.

Ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- reset_i  input  1  reset, asynchronous, active-high.
- clear_i  input  1  synchronous clear; highest priority after reset.
- en_i  input  1  one credit freed this cycle.
- thresh_i  input  width_p  batch threshold; value 0 behaves as 1; quasi-static.
- timeout_i  input  timeout_width_p  idle cycles before a partial batch is flushed; 0 disables the timeout.
- ret_v_o  output  1  batch valid.
- ret_count_o  output  width_p  credits in the batch; stable while ret_v_o=1.
- ret_ready_i  input  1  holder accepts the batch.
- count_o  output  width_p  credits accumulated but not yet placed in a batch.
- overflow_o  output  1  sticky: accumulator saturated and at least one credit was dropped.

## Operation
- Registers:
  - count_r: the accumulator.
  - ret_count_r: the batch snapshot.
  - idle_r: idle-cycle counter.
  - ovf_r: sticky overflow flag.
  - state_r: one of IDLE, ACCUM, SEND.
- inc = count_r + en_i, saturating at all-ones. An en_i=1 that arrives while count_r is all-ones sets ovf_r.
- IDLE (count_r=0):
  - en_i=1 with threshold at most 1 -> SEND, with ret_count_r=1.
  - en_i=1 otherwise -> ACCUM, with count_r=1.
- ACCUM:
  - flush if inc >= max(thresh_i,1), or if timeout is enabled, timeout_i!=0, en_i=0 and idle_r==timeout_i-1.
  - On flush: ret_count_r<=inc, count_r<=0, idle_r<=0, go to SEND.
  - Otherwise: count_r<=inc. idle_r<=0 when en_i=1, else idle_r+1, saturating at all-ones.
- SEND:
  - ret_v_o=1 and ret_count_o=ret_count_r.
  - count_r<=inc, so credits keep accumulating.
  - idle_r is held at 0.
  - On ret_v_o & ret_ready_i: go to ACCUM if inc!=0, else IDLE. The threshold is re-evaluated only from the following cycle.
- clear_i=1: count_r, ret_count_r, idle_r and ovf_r go to 0; state goes to IDLE. A pending batch is discarded and its ret_v_o drops without a handshake.
- Credits are conserved: the sum of all accepted ret_count_o, plus count_o, plus the pending ret_count_r equals the total number of en_i pulses. This holds absent overflow and clear.

## Timing
- Reset values:
  - ret_v_o=0, ret_count_o=0, count_o=0, overflow_o=0.
  - state IDLE, idle_r=0.
- All outputs are registered; there is no combinational path from input to output.
- Latency: the en_i edge that triggers a flush gives ret_v_o=1 on the next cycle. A threshold flush therefore includes the triggering credit.
- Handshake:
  - ret_v_o stays high and ret_count_o stays constant until accepted.
  - ret_ready_i may be asserted before ret_v_o and may be high permanently.
- After acceptance there is a minimum of one cycle with ret_v_o=0 before the next batch.
- reset_i asserted mid-batch: outputs clear immediately (asynchronously), and the batch is lost.
- Simultaneous events:
  - en_i together with acceptance: the credit goes into count_r, and the state goes to ACCUM.
  - en_i with saturation: the count is held, ovf_r=1.
  - clear_i with en_i: the clear wins and the credit is dropped.

## Configuration
- Macro QCL_CREDIT_TIMEOUT_EN.
  - Defined: the idle-timeout flush and idle_r are present as described above.
  - Undefined: idle_r is not built and timeout_i is ignored, although the port remains. Only the threshold triggers a flush, so a partial batch waits until the threshold is reached.

## Structure
- Shared package qcl_pkg:
  - typedef qcl_cr_state_e with values IDLE, ACCUM, SEND.
  - Constant for the minimum effective threshold (1).
- Sub-module qcl_counter_overflow_clear_en: up-counter with synchronous clear, enable, and saturation/overflow flag. It is instantiated once for idle_r and only under QCL_CREDIT_TIMEOUT_EN.
- The FSM, accumulator and snapshot register are inline.

## Test plan
- Threshold batch: thresh_i=4, timeout disabled, ret_ready_i=1, en_i=1 for 4 cycles -> ret_v_o=1 one cycle later with ret_count_o=4; count_o returns to 0.
- Timeout flush (macro defined): thresh_i=10, timeout_i=3, 2 en_i pulses followed by silence -> ret_v_o=1 with ret_count_o=2, 4 cycles after the last pulse.
- Backpressure: thresh_i=2, ret_ready_i=0 for 10 cycles while en_i=1 continuously.
  - ret_count_o holds 2 and ret_v_o stays high; count_o=10.
  - On acceptance, the next batch is 10 or more.
- Saturation: width_p=4, thresh_i=0xF, ret_ready_i=0, 40 pulses -> count_o saturates at 15 and overflow_o=1; it remains 1 until clear_i.
- Clear and reset mid-batch:
  - clear_i while ret_v_o=1 -> next cycle ret_v_o=0, count_o=0, overflow_o=0.
  - reset_i asserted asynchronously -> outputs are 0 before the next clock edge.
- Conservation: random en_i and ret_ready_i for 10k cycles with thresh_i=5, timeout_i=7 -> the sum of accepted counts plus the outstanding credits equals the number of pulses.
